// File: rtl/fp16_pkg.sv
// Shared FP16 field layout, exponent constants and operand classes, used by the
// integer converter and the adder special-case logic.
package fp16_pkg;

    localparam int         FP16_EXP_BIAS = 15;
    localparam logic [4:0] FP16_EXP_MAX  = 5'h1F;

    localparam int SIGN_BIT = 15;
    localparam int EXP_MSB  = 14;
    localparam int EXP_LSB  = 10;
    localparam int MAN_MSB  = 9;
    localparam int MAN_LSB  = 0;

    typedef enum logic [2:0] {
        FP_ZERO = 3'd0,
        FP_SUB  = 3'd1,
        FP_NORM = 3'd2,
        FP_INF  = 3'd3,
        FP_NAN  = 3'd4
    } fp_class_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational FP16 unpack: splits a binary16 word into fields and classifies it
// as zero, subnormal, normal, infinity or NaN.
module fp16_classify
    import fp16_pkg::*;
(
    input  logic [15:0] a,
    output logic        sign,
    output logic [4:0]  a_exp,
    output logic [9:0]  a_man,
    output fp_class_t   cls
);

    assign sign  = a[SIGN_BIT];
    assign a_exp = a[EXP_MSB:EXP_LSB];
    assign a_man = a[MAN_MSB:MAN_LSB];

    always_comb begin
        cls = FP_NORM;
        if (a_exp == 5'd0) begin
            cls = (a_man == 10'd0) ? FP_ZERO : FP_SUB;
        end else if (a_exp == FP16_EXP_MAX) begin
            cls = (a_man == 10'd0) ? FP_INF : FP_NAN;
        end
    end

endmodule

// File: rtl/fp16_to_int_conv.sv
// Three-stage FP16 -> signed integer converter (classify, align, round/saturate).
// Define FP16_CONV_RNE_EN for round-half-to-even; otherwise results truncate toward zero.
module fp16_to_int_conv
    import fp16_pkg::*;
#(
    parameter int OUT_W    = 16,
    parameter int EXP_BIAS = FP16_EXP_BIAS
) (
    input  logic             clk_59,
    input  logic             rst_59,
    input  logic [15:0]      A_59,
    input  logic             in_valid_59,
    output logic             in_ready_59,
    output logic [OUT_W-1:0] C_59,
    output logic             ovf_59,
    output logic             inexact_59,
    output logic             invalid_59,
    output logic             out_valid_59,
    input  logic             out_ready_59
);

    localparam logic [17:0]      POS_LIM = 18'((1 << (OUT_W - 1)) - 1);
    localparam logic [17:0]      NEG_LIM = 18'(1 << (OUT_W - 1));
    localparam logic [OUT_W-1:0] SAT_POS = {1'b0, {(OUT_W - 1){1'b1}}};
    localparam logic [OUT_W-1:0] SAT_NEG = {1'b1, {(OUT_W - 1){1'b0}}};

    // Handshake: a word transfers on any edge where valid and ready are both high.
    // The whole pipe moves as one (advance) whenever the output slot is empty or
    // being taken, so in_ready_59 follows advance and bubbles stay in place.
    logic advance;
    assign advance     = ~out_valid_59 | out_ready_59;
    assign in_ready_59 = advance;

    logic            c_sign;
    logic [4:0]      c_exp;
    logic [9:0]      c_man;
    fp_class_t       c_cls;
    logic [5:0]      c_sh;

    fp16_classify u_classify (
        .a     (A_59),
        .sign  (c_sign),
        .a_exp (c_exp),
        .a_man (c_man),
        .cls   (c_cls)
    );

    assign c_sh = {1'b0, c_exp} - 6'(EXP_BIAS);

    logic            s1_valid, s1_sign;
    fp_class_t       s1_cls;
    logic [5:0]      s1_sh;
    logic [10:0]     s1_sig;

    always_ff @(posedge clk_59 or posedge rst_59) begin
        if (rst_59) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_cls   <= FP_ZERO;
            s1_sh    <= 6'd0;
            s1_sig   <= 11'd0;
        end else if (advance) begin
            s1_valid <= in_valid_59;
            s1_sign  <= c_sign;
            s1_cls   <= c_cls;
            s1_sh    <= c_sh;
            s1_sig   <= {1'b1, c_man};
        end
    end

    logic [25:0] al_shifted;
    logic [16:0] al_mag;
    logic        al_guard, al_sticky;

    assign al_shifted = {15'd0, s1_sig} << s1_sh[4:0];

    // Below 1.0 only the -1 shift can put the half-point in the guard position.
    always_comb begin
        al_mag    = 17'd0;
        al_guard  = 1'b0;
        al_sticky = 1'b0;
        if (s1_cls == FP_NORM) begin
            if (!s1_sh[5]) begin
                al_mag    = {1'b0, al_shifted[25:10]};
                al_guard  = al_shifted[9];
                al_sticky = |al_shifted[8:0];
            end else if (s1_sh == 6'h3F) begin
                al_guard  = 1'b1;
                al_sticky = |s1_sig[9:0];
            end else begin
                al_sticky = 1'b1;
            end
        end
    end

    logic            s2_valid, s2_sign, s2_guard, s2_sticky;
    fp_class_t       s2_cls;
    logic [16:0]     s2_mag;

    always_ff @(posedge clk_59 or posedge rst_59) begin
        if (rst_59) begin
            s2_valid  <= 1'b0;
            s2_sign   <= 1'b0;
            s2_cls    <= FP_ZERO;
            s2_mag    <= 17'd0;
            s2_guard  <= 1'b0;
            s2_sticky <= 1'b0;
        end else if (advance) begin
            s2_valid  <= s1_valid;
            s2_sign   <= s1_sign;
            s2_cls    <= s1_cls;
            s2_mag    <= al_mag;
            s2_guard  <= al_guard;
            s2_sticky <= al_sticky;
        end
    end

    logic [17:0]      r_mag;
    logic [OUT_W-1:0] neg_mag;

`ifdef FP16_CONV_RNE_EN
    assign r_mag = {1'b0, s2_mag} + 18'(s2_guard & (s2_sticky | s2_mag[0]));
`else
    assign r_mag = {1'b0, s2_mag};
`endif
    assign neg_mag = -r_mag[OUT_W-1:0];

    logic [OUT_W-1:0] n_c;
    logic             n_ovf, n_inex, n_inv;

    always_comb begin
        n_c    = '0;
        n_ovf  = 1'b0;
        n_inex = 1'b0;
        n_inv  = 1'b0;
        case (s2_cls)
            FP_ZERO: ;
            FP_SUB:  n_inex = 1'b1;
            FP_INF: begin
                n_ovf = 1'b1;
                n_c   = s2_sign ? SAT_NEG : SAT_POS;
            end
            FP_NAN:  n_inv = 1'b1;
            default: begin
                if (!s2_sign && r_mag > POS_LIM) begin
                    n_ovf = 1'b1;
                    n_c   = SAT_POS;
                end else if (s2_sign && r_mag > NEG_LIM) begin
                    n_ovf = 1'b1;
                    n_c   = SAT_NEG;
                end else begin
                    n_c    = s2_sign ? neg_mag : r_mag[OUT_W-1:0];
                    n_inex = s2_guard | s2_sticky;
                end
            end
        endcase
    end

    always_ff @(posedge clk_59 or posedge rst_59) begin
        if (rst_59) begin
            out_valid_59 <= 1'b0;
            C_59         <= '0;
            ovf_59       <= 1'b0;
            inexact_59   <= 1'b0;
            invalid_59   <= 1'b0;
        end else if (advance) begin
            out_valid_59 <= s2_valid;
            C_59         <= n_c;
            ovf_59       <= n_ovf;
            inexact_59   <= n_inex;
            invalid_59   <= n_inv;
        end
    end

endmodule
